key_event_ctrl: RTL and testbench

//  Classifies debounced key levels into SHORT / LONG / REPEAT events for the clock's time-setting UI.

---
 rtl/key_event_ctrl.sv | 173 +++++++++++++++++
 tb/tb_key_event_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
// Key event classifier: turns debounced key levels into SHORT/LONG/REPEAT events on one valid/ready port.
// Optional KEY_REPEAT_EN: when defined, a held key emits REPEAT every REP_MS ticks after LONG.
//
// state  | meaning
// S_IDLE | key released, or held since reset / since before the last press
// S_DOWN | pressed, counting ticks towards LONG_MS
// S_HOLD | LONG already posted, waiting for release (and pacing REPEAT when enabled)
module key_event_ctrl #(
  parameter int NUM_KEYS = 4,
  parameter int TICK_DIV = 50000,
  parameter int LONG_MS  = 1000,
  parameter int REP_MS   = 200,
  localparam int KW      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_down,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [KW-1:0]       ev_key,
  output logic [1:0]          ev_type,
  output logic                ovf,
  input  logic                ovf_clr
);

  localparam int MAXV = (LONG_MS > REP_MS) ? LONG_MS : REP_MS;
  localparam int CW   = $clog2(MAXV + 1);
  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] EV_SHORT  = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
  localparam logic [1:0] EV_REPEAT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_DOWN, S_HOLD} key_st_t;

  key_st_t                 st_q   [NUM_KEYS];
  key_st_t                 st_d   [NUM_KEYS];
  logic [CW-1:0]           cnt_q  [NUM_KEYS];
  logic [CW-1:0]           cnt_d  [NUM_KEYS];
  logic [1:0]              post_type [NUM_KEYS];
  logic [1:0]              ptype_q   [NUM_KEYS];
  logic [NUM_KEYS-1:0]     post;
  logic [NUM_KEYS-1:0]     pend_q;
  logic [NUM_KEYS-1:0]     prev_q;
  logic [NUM_KEYS-1:0]     rise;
  logic [NUM_KEYS-1:0]     gclr;
  logic [TW-1:0]           tcnt_q;
  logic                    tick;
  logic                    free;
  logic                    found;
  logic                    grant;
  logic [KW-1:0]           grant_idx;
  logic [KW-1:0]           last_q;
  logic                    drop;

  assign tick = (tcnt_q == TW'(TICK_DIV - 1));
  assign rise = key_down & ~prev_q;
  assign free = !ev_valid || ev_ready;

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      st_d[i]      = st_q[i];
      cnt_d[i]     = cnt_q[i];
      post[i]      = 1'b0;
      post_type[i] = 2'b00;
      case (st_q[i])
        S_IDLE: begin
          if (rise[i]) begin
            st_d[i]  = S_DOWN;
            cnt_d[i] = '0;
          end
        end
        S_DOWN: begin
          // Threshold takes precedence over a release in the same cycle.
          if (tick && cnt_q[i] == CW'(LONG_MS - 1)) begin
            post[i]      = 1'b1;
            post_type[i] = EV_LONG;
            cnt_d[i]     = '0;
            st_d[i]      = key_down[i] ? S_HOLD : S_IDLE;
          end else if (!key_down[i]) begin
            post[i]      = 1'b1;
            post_type[i] = EV_SHORT;
            st_d[i]      = S_IDLE;
          end else if (tick) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        S_HOLD: begin
`ifdef KEY_REPEAT_EN
          if (tick && cnt_q[i] == CW'(REP_MS - 1)) begin
            post[i]      = 1'b1;
            post_type[i] = EV_REPEAT;
            cnt_d[i]     = '0;
            st_d[i]      = key_down[i] ? S_HOLD : S_IDLE;
          end else if (!key_down[i]) begin
            st_d[i] = S_IDLE;
          end else if (tick) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
`else
          if (!key_down[i]) begin
            st_d[i] = S_IDLE;
          end
`endif
        end
        default: st_d[i] = S_IDLE;
      endcase
    end
  end

  // Round-robin search starting just after the last granted key.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_KEYS; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NUM_KEYS;
      if (!found && pend_q[idx[KW-1:0]]) begin
        found     = 1'b1;
        grant_idx = idx[KW-1:0];
      end
    end
    grant = found && free;
    gclr  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (grant && grant_idx == KW'(i)) gclr[i] = 1'b1;
    end
    drop = |(post & pend_q & ~gclr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        st_q[i]    <= S_IDLE;
        cnt_q[i]   <= '0;
        ptype_q[i] <= 2'b00;
      end
      pend_q   <= '0;
      prev_q   <= '1;
      tcnt_q   <= '0;
      last_q   <= KW'(NUM_KEYS - 1);
      ev_valid <= 1'b0;
      ev_key   <= '0;
      ev_type  <= 2'b00;
      ovf      <= 1'b0;
    end else begin
      prev_q <= key_down;
      tcnt_q <= tick ? '0 : tcnt_q + 1'b1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        // A new post beats a grant clear of the same key.
        if (post[i]) begin
          pend_q[i]  <= 1'b1;
          ptype_q[i] <= post_type[i];
        end else if (gclr[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (grant) begin
        ev_valid <= 1'b1;
        ev_key   <= grant_idx;
        ev_type  <= ptype_q[grant_idx];
        last_q   <= grant_idx;
      end else if (free) begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with an event scoreboard (TICK_DIV=4, LONG_MS=10, REP_MS=3).
module tb_key_event_ctrl;
  localparam int NK = 4;
  localparam int TD = 4;
  localparam int LM = 10;
  localparam int RM = 3;
  localparam logic [1:0] SHORT  = 2'b01;
  localparam logic [1:0] LONG   = 2'b10;
  localparam logic [1:0] REPEAT = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_down = '0;
  logic          ev_ready = 1'b1;
  logic          ovf_clr = 1'b0;
  logic          ev_valid;
  logic [1:0]    ev_key;
  logic [1:0]    ev_type;
  logic          ovf;

  typedef struct packed {logic [1:0] key; logic [1:0] typ;} ev_t;
  ev_t exq[$];
  ev_t e;
  int  acc_cyc[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  int  n0;

  key_event_ctrl #(.NUM_KEYS(NK), .TICK_DIV(TD), .LONG_MS(LM), .REP_MS(RM)) dut (
    .clk(clk), .rst(rst), .key_down(key_down), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_key(ev_key), .ev_type(ev_type), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every accepted event is checked against the front of the expectation queue.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      n_cmp++;
      assert (exq.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_event observed key=%0d type=%b expected none", ev_key, ev_type);
      end
      if (exq.size() > 0) begin
        e = exq.pop_front();
        n_cmp++;
        assert (ev_key === e.key && ev_type === e.typ) else begin
          n_err++;
          $error("FAIL event observed key=%0d type=%b expected key=%0d type=%b",
                 ev_key, ev_type, e.key, e.typ);
        end
      end
      acc_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    step(n * TD);
  endtask

  task automatic press(input int k, input int nt);
    key_down[k] = 1'b1;
    ticks(nt);
    key_down[k] = 1'b0;
    step(2);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && exq.size() != 0; i++) step(1);
    chk(tag, exq.size(), 0);
    step(4);
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ev_key", ev_key, 0);
    chk("rst_ev_type", ev_type, 0);
    step(3);
    chk("idle_ev_valid", ev_valid, 0);

    // 1: short press on key 1
    exq.push_back('{2'd1, SHORT});
    press(1, 5);
    wait_drain("t1_drain");

    // 2: long hold on key 0
    exq.push_back('{2'd0, LONG});
`ifdef KEY_REPEAT_EN
    repeat (3) exq.push_back('{2'd0, REPEAT});
`endif
    n0 = acc_cyc.size();
    key_down[0] = 1'b1;
    step(34);
    chk("t2_long_not_early", acc_cyc.size(), n0);
    step(12);
    chk("t2_long_seen", acc_cyc.size(), n0 + 1);
    step(34);
    key_down[0] = 1'b0;
    wait_drain("t2_drain");
    step(60);
`ifdef KEY_REPEAT_EN
    chk("t2_event_count", acc_cyc.size(), n0 + 4);
`else
    chk("t2_event_count", acc_cyc.size(), n0 + 1);
`endif

    // 3: simultaneous releases, from a fresh grant pointer
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    for (int r = 0; r < 2; r++) begin
      exq.push_back('{2'd0, SHORT});
      exq.push_back('{2'd2, SHORT});
      key_down = 4'b0101;
      ticks(2);
      key_down = 4'b0000;
      step(6);
      chk("t3_drain", exq.size(), 0);
      chk("t3_back_to_back", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], 1);
      step(4);
    end

    // 4: back-pressure and overflow on key 3
    ev_ready = 1'b0;
    press(3, 2);
    step(2);
    chk("t4_valid", ev_valid, 1);
    chk("t4_key", ev_key, 3);
    chk("t4_type", ev_type, SHORT);
    chk("t4_ovf0", ovf, 0);
    press(3, 2);
    step(2);
    chk("t4_hold_valid", ev_valid, 1);
    chk("t4_hold_key", ev_key, 3);
    chk("t4_ovf1", ovf, 0);
    press(3, 2);
    step(2);
    chk("t4_ovf_set", ovf, 1);
    chk("t4_hold_type", ev_type, SHORT);
    exq.push_back('{2'd3, SHORT});
    exq.push_back('{2'd3, SHORT});
    ev_ready = 1'b1;
    wait_drain("t4_drain");
    chk("t4_ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", ovf, 0);

    // 5: key held across reset
    key_down[2] = 1'b1;
    step(3);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    n0 = acc_cyc.size();
    ticks(5);
    key_down[2] = 1'b0;
    step(20);
    chk("t5_no_event", acc_cyc.size(), n0);
    chk("t5_ev_valid", ev_valid, 0);
    exq.push_back('{2'd2, SHORT});
    press(2, 2);
    wait_drain("t5_drain");

    // 6: reset while an event is stalled on the port
    ev_ready = 1'b0;
    key_down[1] = 1'b1;
    for (int i = 0; i < 120 && !ev_valid; i++) step(1);
    chk("t6_long_valid", ev_valid, 1);
    chk("t6_long_type", ev_type, LONG);
    ticks(8);
    rst = 1'b1;
    step(1);
    chk("t6_rst_valid", ev_valid, 0);
    chk("t6_rst_ovf", ovf, 0);
    rst = 1'b0;
    ev_ready = 1'b1;
    n0 = acc_cyc.size();
    ticks(12);
    key_down[1] = 1'b0;
    step(20);
    chk("t6_no_event", acc_cyc.size(), n0);
    exq.push_back('{2'd1, SHORT});
    press(1, 3);
    wait_drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
